scratch_ctrl: RTL
=================

Name: scratch_ctrl

Overview:
- Sequences the two PIO scratch registers X and Y for one state machine.
- Accepts decoded scratch operations from the instruction decoder: set, post-decrement, move.
- Produces jump-condition flags and a registered "decrement taken" pulse for JMP X-- / JMP Y--.
- Enforces the instruction delay field, holding off the next operation for the programmed number of enabled cycles.

Parameters:
WIDTH, 32, scratch register width
DELAY_W, 5, width of delay field (max delay 2^DELAY_W-1 cycles)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
penable  input  1  state-machine clock enable (fractional divider tick)
stall_in  input  1  external stall (FIFO full/empty, WAIT); blocks op acceptance
op_valid  input  1  decoder presents an operation
op  input  3  0 NOP, 1 SET_X, 2 SET_Y, 3 DEC_X, 4 DEC_Y, 5 MOV_X_Y (x<=y), 6 MOV_Y_X (y<=x), 7 reserved (treated as NOP)
din  input  WIDTH  data for SET_X/SET_Y
delay  input  DELAY_W  delay cycles following this op
op_ready  output  1  controller can accept an op this cycle
x  output  WIDTH  X register
y  output  WIDTH  Y register
x_nz  output  1  x != 0 (combinational)
y_nz  output  1  y != 0 (combinational)
x_ne_y  output  1  x != y (combinational)
dec_taken  output  1  one-cycle pulse: last accepted DEC had nonzero pre-value
busy  output  1  in DELAY state

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset.
- Reset: x=0, y=0, state=RUN, delay counter=0, dec_taken=0, busy=0.
- States: RUN, DELAY.
- op_ready = (state==RUN) && !stall_in.
- accept = op_valid && op_ready && penable.
- On accept, the op takes effect at that clock edge; x/y show the new value next cycle (latency 1).
  - SET_*: reg <= din.
  - DEC_*: reg <= reg-1, modulo 2^WIDTH; 0 wraps to all ones.
  - MOV_X_Y / MOV_Y_X: copy the pre-edge value of the other register.
  - NOP/reserved: no register change; the delay still applies.
- dec_taken:
  - Asserted for exactly one clk cycle after an accepted DEC_* whose pre-decrement value was nonzero (PIO JMP X-- semantics).
  - 0 after every other op and when nothing is accepted.
- Delay:
  - On accept with delay!=0: state<=DELAY, counter<=delay.
  - In DELAY, each cycle with penable=1 decrements the counter.
  - Counter reaching 0 returns state to RUN in the same edge.
  - Net result: exactly `delay` enabled cycles pass with op_ready=0 before the next accept.
  - stall_in does not pause the delay count.
  - With delay==0, state stays RUN and back-to-back accepts are allowed.
- penable=0: no accept, delay counter frozen, registers hold, dec_taken cleared.
- stall_in=1 in RUN: no accept, no register change, the op must be re-presented.
- Condition flags are combinational from current x/y and valid in every state.
- Reset mid-DELAY or mid-op: immediate return to the reset state; any pending delay is discarded.
- Only one op per accept; X and Y are never both written by one op except by reset.

Decomposition:
- Shared pio package:
  - op encoding constants SCR_NOP..SCR_MOV_Y_X.
  - state encoding (RUN=0, DELAY=1).
  - default WIDTH/DELAY_W.
- One natural sub-module: scratch_delay_cnt, a loadable down-counter with penable gating and a zero flag. The registers and op decode stay in the top module.

Test Plan:
- Reset, then SET_X din=5 delay=0 -> x=5 next cycle, x_nz=1, op_ready stays 1.
- x=1, DEC_X -> x=0, dec_taken pulse=1; DEC_X again -> x=32'hFFFFFFFF, dec_taken=0.
- SET_Y din=7 with delay=3, penable toggling 1,0,1,1,1 -> op_ready low for exactly 3 penable=1 cycles (4 clk cycles), busy matches, next op accepted after.
- stall_in=1 with op_valid and DEC_Y -> y unchanged, op_ready=0; stall released -> y decremented once only.
- x=3, y=9, MOV_X_Y -> x=9, x_ne_y=0; then MOV_Y_X with din ignored -> y=9.
- Reset asserted during DELAY with counter=4 -> next cycle state RUN, x=y=0, busy=0, op_ready=1.

Source files
------------

// File: rtl/scratch_ctrl_pkg.sv
// Shared definitions for the PIO scratch-register controller: op codes, FSM states, default widths.
package scratch_ctrl_pkg;

    localparam int SCR_WIDTH   = 32;
    localparam int SCR_DELAY_W = 5;

    localparam logic [2:0] SCR_NOP     = 3'd0;
    localparam logic [2:0] SCR_SET_X   = 3'd1;
    localparam logic [2:0] SCR_SET_Y   = 3'd2;
    localparam logic [2:0] SCR_DEC_X   = 3'd3;
    localparam logic [2:0] SCR_DEC_Y   = 3'd4;
    localparam logic [2:0] SCR_MOV_X_Y = 3'd5;
    localparam logic [2:0] SCR_MOV_Y_X = 3'd6;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DELAY = 1'b1
    } scr_state_t;

endpackage

// File: rtl/scratch_ctrl_delay_cnt.sv
// Loadable down-counter for the instruction delay field; counts only on enabled ticks and stops at zero.
module scratch_delay_cnt
    import scratch_ctrl_pkg::*;
#(
    parameter int DELAY_W = SCR_DELAY_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DELAY_W-1:0] load_val,
    input  logic               en,
    output logic [DELAY_W-1:0] count,
    output logic               zero
);

    assign zero = (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !zero) begin
            count <= count - DELAY_W'(1);
        end
    end

endmodule

// File: rtl/scratch_ctrl.sv
// X/Y scratch registers for one PIO state machine: executes set/decrement/move ops and holds off
// the next op for the programmed delay.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_RUN   | ready for an op (unless stalled)
//   ST_DELAY | counting down the delay of the last op; ops are refused
module scratch_ctrl
    import scratch_ctrl_pkg::*;
#(
    parameter int WIDTH   = SCR_WIDTH,
    parameter int DELAY_W = SCR_DELAY_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               penable,
    input  logic               stall_in,
    input  logic               op_valid,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   din,
    input  logic [DELAY_W-1:0] delay,
    output logic               op_ready,
    output logic [WIDTH-1:0]   x,
    output logic [WIDTH-1:0]   y,
    output logic               x_nz,
    output logic               y_nz,
    output logic               x_ne_y,
    output logic               dec_taken,
    output logic               busy
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    scr_state_t         state;
    logic               accept;
    logic [DELAY_W-1:0] cnt;
    logic               cnt_zero;

    assign op_ready = (state == ST_RUN) && !stall_in;
    assign accept   = op_valid && op_ready && penable;

    assign x_nz   = (x != '0);
    assign y_nz   = (y != '0);
    assign x_ne_y = (x != y);

    scratch_delay_cnt #(.DELAY_W(DELAY_W)) u_delay_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (delay),
        .en       (penable),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            busy      <= 1'b0;
            x         <= '0;
            y         <= '0;
            dec_taken <= 1'b0;
        end else begin
            dec_taken <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (accept) begin
                        case (op)
                            SCR_SET_X:   x <= din;
                            SCR_SET_Y:   y <= din;
                            SCR_DEC_X: begin
                                x         <= x - ONE;
                                dec_taken <= (x != '0);
                            end
                            SCR_DEC_Y: begin
                                y         <= y - ONE;
                                dec_taken <= (y != '0);
                            end
                            SCR_MOV_X_Y: x <= y;
                            SCR_MOV_Y_X: y <= x;
                            default: ;
                        endcase
                        if (delay != '0) begin
                            state <= ST_DELAY;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_DELAY: begin
                    // Leave on the tick that takes the counter to zero, so exactly `delay`
                    // enabled cycles elapse; an already-zero counter never strands the FSM.
                    if (cnt_zero || (penable && cnt == DELAY_W'(1))) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
